apb_initiator: RTL and testbench

- Converts single-outstanding CPU-side requests (valid/ready) into APB4 transfers, driving peripherals such as the GPIO, UART and SPI slaves on the SoC APB bus.
- Returns read data or error on a response channel.
- A configurable timeout terminates transfers to a slave that never asserts pready, so the core cannot hang.

---
 rtl/apb_initiator.sv | 166 ++++++++++++++++
 tb/tb_apb_initiator.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_initiator.sv
// APB4 initiator: turns single-outstanding valid/ready requests into APB
// transfers. A response channel returns the read data or the error status.
module apb_initiator #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic                req_write,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wstrb,
    input  logic [2:0]          req_prot,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,
    output logic [ADDR_W-1:0]   out_paddr,
    output logic                out_psel,
    output logic                out_penable,
    output logic [2:0]          out_pprot,
    output logic                out_pwrite,
    output logic [DATA_W-1:0]   out_pwdata,
    output logic [DATA_W/8-1:0] out_pstrb,
    input  logic                out_pready,
    input  logic [DATA_W-1:0]   out_prdata,
    input  logic                out_pslverr
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
    logic [2:0]          pprot_q, pprot_d;
    logic                pwrite_q, pwrite_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic [STRB_W-1:0]   pstrb_q, pstrb_d;
    logic                resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
    logic                resp_err_q, resp_err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                to_hit;

    // Limit is hit on the ACCESS cycle that would bring the count to TIMEOUT.
    assign to_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d      = state_q;
        paddr_d      = paddr_q;
        psel_d       = psel_q;
        penable_d    = penable_q;
        pprot_d      = pprot_q;
        pwrite_d     = pwrite_q;
        pwdata_d     = pwdata_q;
        pstrb_d      = pstrb_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        cnt_d        = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    paddr_d  = req_addr;
                    pwrite_d = req_write;
                    pwdata_d = req_wdata;
                    pprot_d  = req_prot;
                    pstrb_d  = req_write ? req_wstrb : '0;
                    psel_d   = 1'b1;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (out_pready) begin
                    resp_err_d   = out_pslverr;
                    resp_rdata_d = (pwrite_q || out_pslverr) ? '0
                                                             : out_prdata;
                    psel_d       = 1'b0;
                    penable_d    = 1'b0;
                    resp_valid_d = 1'b1;
                    cnt_d        = '0;
                    state_d      = RESP;
                end else if (to_hit) begin
                    resp_err_d   = 1'b1;
                    resp_rdata_d = '0;
                    psel_d       = 1'b0;
                    penable_d    = 1'b0;
                    resp_valid_d = 1'b1;
                    cnt_d        = '0;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            paddr_q      <= '0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            pprot_q      <= '0;
            pwrite_q     <= 1'b0;
            pwdata_q     <= '0;
            pstrb_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            paddr_q      <= paddr_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            pprot_q      <= pprot_d;
            pwrite_q     <= pwrite_d;
            pwdata_q     <= pwdata_d;
            pstrb_q      <= pstrb_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            cnt_q        <= cnt_d;
        end
    end

    assign req_ready   = (state_q == IDLE);
    assign resp_valid  = resp_valid_q;
    assign resp_rdata  = resp_rdata_q;
    assign resp_err    = resp_err_q;
    assign out_paddr   = paddr_q;
    assign out_psel    = psel_q;
    assign out_penable = penable_q;
    assign out_pprot   = pprot_q;
    assign out_pwrite  = pwrite_q;
    assign out_pwdata  = pwdata_q;
    assign out_pstrb   = pstrb_q;

endmodule

// File: tb/tb_apb_initiator.sv
// Directed bench for apb_initiator with TIMEOUT=4: zero-wait write, waited
// read, slave error, timeout, response backpressure and async reset.
module tb_apb_initiator;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_write;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic [2:0]  req_prot;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] out_paddr;
    logic        out_psel;
    logic        out_penable;
    logic [2:0]  out_pprot;
    logic        out_pwrite;
    logic [31:0] out_pwdata;
    logic [3:0]  out_pstrb;
    logic        out_pready;
    logic [31:0] out_prdata;
    logic        out_pslverr;

    int checks = 0;
    int failures = 0;

    apb_initiator #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_write(req_write),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .req_prot(req_prot),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .out_paddr(out_paddr), .out_psel(out_psel),
        .out_penable(out_penable), .out_pprot(out_pprot),
        .out_pwrite(out_pwrite), .out_pwdata(out_pwdata),
        .out_pstrb(out_pstrb), .out_pready(out_pready),
        .out_prdata(out_prdata), .out_pslverr(out_pslverr)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] a, input logic w,
                        input logic [31:0] d, input logic [3:0] s,
                        input logic [2:0] p);
        req_valid = 1'b1;
        req_addr  = a;
        req_write = w;
        req_wdata = d;
        req_wstrb = s;
        req_prot  = p;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        req_valid = 1'b0;
        req_addr = '0;
        req_write = 1'b0;
        req_wdata = '0;
        req_wstrb = '0;
        req_prot = '0;
        resp_ready = 1'b1;
        out_pready = 1'b0;
        out_prdata = '0;
        out_pslverr = 1'b0;
        #2;
        chk("rst_psel", 32'(out_psel), 32'd0);
        chk("rst_penable", 32'(out_penable), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_paddr", out_paddr, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Zero-wait write
        out_pready = 1'b1;
        send(32'h1000_0000, 1'b1, 32'h0000_A5A5, 4'h3, 3'h2);
        chk("wr_req_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        chk("wr_t1_psel", 32'(out_psel), 32'd1);
        chk("wr_t1_penable", 32'(out_penable), 32'd0);
        chk("wr_t1_req_ready", 32'(req_ready), 32'd0);
        chk("wr_paddr", out_paddr, 32'h1000_0000);
        chk("wr_pwdata", out_pwdata, 32'h0000_A5A5);
        chk("wr_pstrb", 32'(out_pstrb), 32'h3);
        chk("wr_pwrite", 32'(out_pwrite), 32'd1);
        chk("wr_pprot", 32'(out_pprot), 32'h2);
        tick();
        chk("wr_t2_psel", 32'(out_psel), 32'd1);
        chk("wr_t2_penable", 32'(out_penable), 32'd1);
        tick();
        chk("wr_t3_resp_valid", 32'(resp_valid), 32'd1);
        chk("wr_t3_err", 32'(resp_err), 32'd0);
        chk("wr_t3_rdata", resp_rdata, 32'd0);
        chk("wr_t3_psel", 32'(out_psel), 32'd0);
        tick();
        chk("wr_t4_resp_valid", 32'(resp_valid), 32'd0);
        chk("wr_t4_req_ready", 32'(req_ready), 32'd1);

        // Read with 3 wait states
        out_pready = 1'b0;
        out_prdata = 32'h0000_00F0;
        send(32'h2000_0010, 1'b0, 32'hFFFF_FFFF, 4'hF, 3'h0);
        tick();
        req_valid = 1'b0;
        chk("rd_pstrb", 32'(out_pstrb), 32'h0);
        chk("rd_pwrite", 32'(out_pwrite), 32'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rd_acc%0d_penable", i), 32'(out_penable), 32'd1);
            chk($sformatf("rd_acc%0d_paddr", i), out_paddr, 32'h2000_0010);
            if (i == 3) out_pready = 1'b1;
            tick();
        end
        out_pready = 1'b0;
        chk("rd_resp_valid", 32'(resp_valid), 32'd1);
        chk("rd_rdata", resp_rdata, 32'h0000_00F0);
        chk("rd_err", 32'(resp_err), 32'd0);
        chk("rd_penable_off", 32'(out_penable), 32'd0);
        tick();

        // Slave error on read
        out_prdata = 32'h0;
        out_pslverr = 1'b1;
        out_pready = 1'b1;
        send(32'h3000_0000, 1'b0, 32'h0, 4'h0, 3'h1);
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        out_pslverr = 1'b0;
        out_pready = 1'b0;
        chk("err_resp_valid", 32'(resp_valid), 32'd1);
        chk("err_err", 32'(resp_err), 32'd1);
        chk("err_rdata", resp_rdata, 32'd0);
        chk("err_psel", 32'(out_psel), 32'd0);
        chk("err_penable", 32'(out_penable), 32'd0);
        tick();

        // Timeout, pready stuck low
        out_prdata = 32'hDEAD_BEEF;
        send(32'h4000_0000, 1'b0, 32'h0, 4'h0, 3'h0);
        tick();
        req_valid = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("to_acc%0d_psel", i), 32'(out_psel), 32'd1);
            chk($sformatf("to_acc%0d_resp_v", i), 32'(resp_valid), 32'd0);
            tick();
        end
        chk("to_psel", 32'(out_psel), 32'd0);
        chk("to_resp_valid", 32'(resp_valid), 32'd1);
        chk("to_err", 32'(resp_err), 32'd1);
        chk("to_rdata", resp_rdata, 32'd0);
        tick();

        // pready rising on the 4th ACCESS cycle wins over the limit
        out_prdata = 32'h0000_1234;
        send(32'h4000_0004, 1'b0, 32'h0, 4'h0, 3'h0);
        tick();
        req_valid = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) out_pready = 1'b1;
            tick();
        end
        out_pready = 1'b0;
        chk("to4_resp_valid", 32'(resp_valid), 32'd1);
        chk("to4_err", 32'(resp_err), 32'd0);
        chk("to4_rdata", resp_rdata, 32'h0000_1234);
        tick();

        // Response backpressure with a second request pending
        resp_ready = 1'b0;
        out_pready = 1'b1;
        out_prdata = 32'h0000_5555;
        send(32'h5000_0000, 1'b0, 32'h0, 4'h0, 3'h0);
        tick();
        tick();
        tick();
        send(32'h6000_0000, 1'b1, 32'h1111_2222, 4'hC, 3'h0);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp%0d_resp_valid", i), 32'(resp_valid), 32'd1);
            chk($sformatf("bp%0d_rdata", i), resp_rdata, 32'h0000_5555);
            chk($sformatf("bp%0d_req_ready", i), 32'(req_ready), 32'd0);
            chk($sformatf("bp%0d_psel", i), 32'(out_psel), 32'd0);
            tick();
        end
        resp_ready = 1'b1;
        tick();
        chk("bp_hs_resp_valid", 32'(resp_valid), 32'd0);
        chk("bp_hs_req_ready", 32'(req_ready), 32'd1);
        chk("bp_hs_psel", 32'(out_psel), 32'd0);
        tick();
        req_valid = 1'b0;
        chk("bp2_psel", 32'(out_psel), 32'd1);
        chk("bp2_paddr", out_paddr, 32'h6000_0000);
        chk("bp2_pstrb", 32'(out_pstrb), 32'hC);
        tick();
        tick();
        chk("bp2_resp_valid", 32'(resp_valid), 32'd1);
        chk("bp2_rdata", resp_rdata, 32'd0);
        tick();
        out_pready = 1'b0;

        // Async reset during ACCESS
        send(32'h7000_0000, 1'b0, 32'h0, 4'h0, 3'h0);
        tick();
        req_valid = 1'b0;
        tick();
        chk("ar_penable_pre", 32'(out_penable), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_psel", 32'(out_psel), 32'd0);
        chk("ar_penable", 32'(out_penable), 32'd0);
        chk("ar_resp_valid", 32'(resp_valid), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("ar_req_ready", 32'(req_ready), 32'd1);
        chk("ar_resp_valid_post", 32'(resp_valid), 32'd0);
        chk("ar_psel_post", 32'(out_psel), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
